// File: rtl/instr_fetch_pkg.sv
// Shared constants, state encoding and buffer entry layout for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO with flush; head reads as zero while empty.
module instr_fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & ~i_flush & (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: the storage array is not reset; the head is masked by the count, so stale words never escape.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited request issue, in-order response capture,
// redirect flush with discard of in-flight responses.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            out_mem_req_valid,
  output logic [XLEN-1:0] out_mem_req_addr,
  input  logic            in_mem_req_ready,
  input  logic            in_mem_resp_valid,
  input  logic [ILEN-1:0] in_mem_resp_data,
  input  logic            in_redirect_valid,
  input  logic [XLEN-1:0] in_redirect_addr,
  input  logic            in_stall,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] r_pc;
  fetch_state_e    r_state;
  logic [CW-1:0]   r_discard;

  logic [CW-1:0]   w_outstanding;
  logic [CW-1:0]   w_outstanding_next;
  logic [CW-1:0]   w_fifo_count;
  logic [SW-1:0]   w_credit_used;
  logic [XLEN-1:0] w_issue_pc;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic            w_fire;
  logic            w_resp_accept;
  logic            w_push;
  logic            w_pop;

  // Outstanding requests and buffered instructions share one credit pool.
  assign w_credit_used     = SW'(w_outstanding) + SW'(w_fifo_count);
  assign out_mem_req_valid = rst_n & ~in_redirect_valid & (w_credit_used < SW'(DEPTH));
  assign out_mem_req_addr  = r_pc;

  assign w_fire             = out_mem_req_valid & in_mem_req_ready;
  assign w_resp_accept      = in_mem_resp_valid & (w_outstanding != '0);
  assign w_outstanding_next = w_outstanding + CW'(w_fire) - CW'(w_resp_accept);
  assign w_push             = w_resp_accept & (r_state == ST_RUN) & ~in_redirect_valid;
  assign w_pop              = out_valid & ~in_stall & ~in_redirect_valid;
  assign w_push_entry       = '{pc: w_issue_pc, instr: in_mem_resp_data};

  // Issue-order pc of every in-flight request; never flushed so drained responses stay paired.
  instr_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_pc_track (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (1'b0),
    .i_push  (w_fire),
    .i_data  (r_pc),
    .i_pop   (w_resp_accept),
    .o_head  (w_issue_pc),
    .o_count (w_outstanding)
  );

  instr_fetch_fifo #(
    .DEPTH ($bits(fetch_entry_t) > 0 ? DEPTH : 1),
    .WIDTH ($bits(fetch_entry_t))
  ) u_prefetch (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (in_redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_state   <= ST_RUN;
      r_discard <= '0;
    end else if (in_redirect_valid) begin
      // The fire term is zero here, so outstanding_next is what is left in flight after this cycle.
      r_pc      <= align_word(in_redirect_addr);
      r_discard <= w_outstanding_next;
      r_state   <= (w_outstanding_next != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (w_fire) r_pc <= r_pc + PC_STEP;
      if ((r_state == ST_DRAIN) && w_resp_accept) begin
        r_discard <= r_discard - CW'(1);
        if (r_discard == CW'(1)) r_state <= ST_RUN;
      end
    end
  end

  assign out_valid = (w_fifo_count != '0);
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural in-order memory plus a pc/instruction scoreboard.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 4;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_mem_req_valid;
  logic [31:0] out_mem_req_addr;
  logic        in_mem_req_ready;
  logic        in_mem_resp_valid;
  logic [31:0] in_mem_resp_data;
  logic        in_redirect_valid;
  logic [31:0] in_redirect_addr;
  logic        in_stall;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .out_mem_req_valid (out_mem_req_valid),
    .out_mem_req_addr  (out_mem_req_addr),
    .in_mem_req_ready  (in_mem_req_ready),
    .in_mem_resp_valid (in_mem_resp_valid),
    .in_mem_resp_data  (in_mem_resp_data),
    .in_redirect_valid (in_redirect_valid),
    .in_redirect_addr  (in_redirect_addr),
    .in_stall          (in_stall),
    .out_valid         (out_valid),
    .out_instr         (out_instr),
    .out_pc            (out_pc)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          lat = 1;
  int          pop_cnt = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] last_pop_pc = 32'h0;
  logic [31:0] stall_pc;
  rsp_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] fire_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, score pops and requests, advance to next negedge.
  task automatic cyc();
    logic        resp_go;
    logic        fire;
    logic        pop;
    logic [31:0] exp_pc;
    rsp_t        rsp;
    resp_go = !mem_hold && (mem_q.size() != 0) && (mem_q[0].due <= cyc_n);
    in_mem_resp_valid = resp_go;
    in_mem_resp_data  = resp_go ? mem_q[0].data : 32'h0;
    #1;
    fire = out_mem_req_valid && in_mem_req_ready;
    pop  = out_valid && !in_stall && !in_redirect_valid;
    if (out_mem_req_valid) check("req_addr", out_mem_req_addr, model_pc);
    if (pop) begin
      check("sb_expected_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        check("sb_pc", out_pc, exp_pc);
        check("sb_instr", out_instr, mem_word(exp_pc));
      end
      pop_cnt++;
      last_pop_pc = out_pc;
    end
    if (in_redirect_valid) begin
      exp_q.delete();
      model_pc = {in_redirect_addr[31:2], 2'b00};
    end
    if (fire) begin
      rsp.data = mem_word(out_mem_req_addr);
      rsp.due  = cyc_n + lat;
      mem_q.push_back(rsp);
      exp_q.push_back(model_pc);
      fire_log.push_back(out_mem_req_addr);
      model_pc = model_pc + 32'd4;
    end
    if (resp_go) void'(mem_q.pop_front());
    @(negedge clk);
    cyc_n++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_mem_req_ready  = 1'b1;
    in_mem_resp_valid = 1'b0;
    in_mem_resp_data  = 32'h0;
    in_redirect_valid = 1'b0;
    in_redirect_addr  = 32'h0;
    in_stall          = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_req_valid", 32'(out_mem_req_valid), 32'd0);
    check("rst_req_addr", out_mem_req_addr, RESET_PC);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);

    // Stream from reset: addresses 0,4,8..., out_pc 0 at cycle 2, one per cycle after
    rst_n = 1'b1;
    #1;
    check("c0_req_valid", 32'(out_mem_req_valid), 32'd1);
    check("c0_req_addr", out_mem_req_addr, 32'h0);
    cyc();
    check("c1_out_valid", 32'(out_valid), 32'd0);
    check("c1_req_addr", out_mem_req_addr, 32'h4);
    cyc();
    check("c2_out_valid", 32'(out_valid), 32'd1);
    check("c2_out_pc", out_pc, 32'h0);
    pop_cnt = 0;
    repeat (12) cyc();
    check("stream_pops", 32'(pop_cnt), 32'd12);

    // Stall with the buffer filling up
    in_stall = 1'b1;
    stall_pc = out_pc;
    repeat (5) cyc();
    check("stall_req_valid", 32'(out_mem_req_valid), 32'd0);
    check("stall_pc_frozen", out_pc, stall_pc);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    in_stall = 1'b0;
    pop_cnt = 0;
    repeat (10) cyc();
    check("release_pops", 32'(pop_cnt), 32'd10);

    // Redirect with two requests in flight and no response that cycle
    mem_hold = 1'b1;
    cyc();
    in_redirect_valid = 1'b1;
    in_redirect_addr  = 32'h0000_0100;
    cyc();
    in_redirect_valid = 1'b0;
    mem_hold = 1'b0;
    #1;
    check("r38_req_addr", out_mem_req_addr, 32'h0000_0100);
    check("r38_out_valid", 32'(out_valid), 32'd0);
    pop_cnt = 0;
    for (int i = 0; i < 20 && pop_cnt == 0; i++) cyc();
    check("r38_pop_seen", 32'(pop_cnt), 32'd1);
    check("r38_first_pc", last_pop_pc, 32'h0000_0100);
    repeat (6) cyc();

    // Settle to one outstanding, then redirect while a response arrives
    in_mem_req_ready = 1'b0;
    repeat (4) cyc();
    in_mem_req_ready = 1'b1;
    repeat (4) cyc();
    in_redirect_valid = 1'b1;
    in_redirect_addr  = 32'h0000_0200;
    #1;
    check("r39_req_blocked", 32'(out_mem_req_valid), 32'd0);
    cyc();
    in_redirect_valid = 1'b0;
    #1;
    check("r39_req_addr", out_mem_req_addr, 32'h0000_0200);
    check("r39_req_valid", 32'(out_mem_req_valid), 32'd1);
    check("r39_out_valid", 32'(out_valid), 32'd0);
    cyc();
    cyc();
    check("r39_out_valid_late", 32'(out_valid), 32'd1);
    check("r39_out_pc", out_pc, 32'h0000_0200);
    repeat (4) cyc();

    // Address wrap; low target bits ignored
    in_redirect_valid = 1'b1;
    in_redirect_addr  = 32'hFFFF_FFFB;
    cyc();
    in_redirect_valid = 1'b0;
    fire_log.delete();
    #1;
    check("wrap_req_addr", out_mem_req_addr, 32'hFFFF_FFF8);
    repeat (3) cyc();
    check("wrap_fire_cnt", 32'(fire_log.size()), 32'd3);
    if (fire_log.size() >= 3) begin
      check("wrap_fire0", fire_log[0], 32'hFFFF_FFF8);
      check("wrap_fire1", fire_log[1], 32'hFFFF_FFFC);
      check("wrap_fire2", fire_log[2], 32'h0000_0000);
    end
    repeat (6) cyc();

    // Reset while draining
    mem_hold = 1'b1;
    cyc();
    in_redirect_valid = 1'b1;
    in_redirect_addr  = 32'h0000_0300;
    cyc();
    in_redirect_valid = 1'b0;
    mem_hold = 1'b0;
    cyc();
    rst_n = 1'b0;
    in_mem_resp_valid = 1'b0;
    in_mem_resp_data  = 32'h0;
    #1;
    check("r41_req_valid", 32'(out_mem_req_valid), 32'd0);
    check("r41_req_addr", out_mem_req_addr, RESET_PC);
    check("r41_out_valid", 32'(out_valid), 32'd0);
    check("r41_out_instr", out_instr, 32'h0);
    check("r41_out_pc", out_pc, 32'h0);
    mem_q.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fire_log.delete();
    pop_cnt = 0;
    #1;
    check("r41_restart_valid", 32'(out_mem_req_valid), 32'd1);
    repeat (6) cyc();
    check("r41_restart_fires", 32'(fire_log.size() != 0), 32'd1);
    if (fire_log.size() != 0) check("r41_restart_addr", fire_log[0], RESET_PC);
    check("r41_restart_pops", 32'(pop_cnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
